// File: rtl/perceptron_weight_store.sv
// Perceptron weight table for the branch predictor. Each row holds a bias weight plus one
// weight per global-history bit. Lookups return a registered dot product one cycle later;
// training applies a saturating +/-1 step to a whole row. The table clears itself row by row
// after reset before lookups and training are accepted.
module perceptron_weight_store #(
   parameter int unsigned NUM_ROWS = 64,
   parameter int unsigned HIST_LEN = 16,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned PC_WIDTH = 32,
   parameter int unsigned THETA    = 44,
   localparam int unsigned IDX     = $clog2(NUM_ROWS),
   localparam int unsigned SUM_W   = WIDTH + $clog2(HIST_LEN + 1) + 1,
   localparam int unsigned NW      = HIST_LEN + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    lookup_valid,
   input  logic [PC_WIDTH-1:0]     lookup_pc,
   input  logic [HIST_LEN-1:0]     lookup_ghist,
   output logic                    lookup_ready,
   output logic                    rd_valid,
   output logic [IDX-1:0]          rd_index,
   output logic signed [SUM_W-1:0] rd_sum,
   output logic                    rd_taken,
   input  logic                    train_valid,
   input  logic [IDX-1:0]          train_index,
   input  logic [HIST_LEN-1:0]     train_ghist,
   input  logic signed [SUM_W-1:0] train_sum,
   input  logic                    train_taken,
   output logic [15:0]             update_count
);

   typedef enum logic [0:0] {StClear, StReady} state_e;

   localparam logic signed [WIDTH-1:0] WMax = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] WMin = {1'b1, {(WIDTH-1){1'b0}}};

   state_e                  state_q, state_d;
   logic [IDX-1:0]          clr_ptr_q, clr_ptr_d;
   logic                    rd_valid_q, rd_valid_d;
   logic [IDX-1:0]          rd_index_q, rd_index_d;
   logic signed [SUM_W-1:0] rd_sum_q, rd_sum_d;
   logic                    rd_taken_q, rd_taken_d;
   logic [15:0]             update_count_q, update_count_d;

   logic signed [WIDTH-1:0] w_q [NUM_ROWS][NW];
   logic signed [WIDTH-1:0] row_new [NW];
   logic signed [WIDTH-1:0] row_rd [NW];
   logic signed [WIDTH-1:0] wr_data [NW];
   logic                    wr_en;
   logic [IDX-1:0]          wr_row;

   logic [SUM_W:0]          sum_ext, train_abs;
   logic                    train_fire, train_mispred;
   logic [NW-1:0]           train_x, lookup_x;
   logic [IDX-1:0]          lk_idx;
   logic                    lk_fire;
   logic signed [SUM_W-1:0] acc;
   logic                    unused_pc;

   assign unused_pc    = ^{lookup_pc[1:0], lookup_pc[PC_WIDTH-1:2+2*IDX]};
   assign lookup_ready = (state_q == StReady);
   assign rd_valid     = rd_valid_q;
   assign rd_index     = rd_index_q;
   assign rd_sum       = rd_sum_q;
   assign rd_taken     = rd_taken_q;
   assign update_count = update_count_q;

   // Training decision: write on a misprediction or a low-confidence sum.
   always_comb begin
      sum_ext       = {train_sum[SUM_W-1], train_sum};
      train_abs     = train_sum[SUM_W-1] ? ((SUM_W + 1)'(0) - sum_ext) : sum_ext;
      train_mispred = (~train_sum[SUM_W-1]) != train_taken;
      train_fire    = (state_q == StReady) && train_valid &&
                      (train_mispred || (train_abs <= (SUM_W + 1)'(THETA)));
   end

   // Saturating update of the trained row; bit i of train_x set means x_i = +1.
   always_comb begin
      train_x = {train_ghist, 1'b1};
      for (int i = 0; i < NW; i++) begin
         row_new[i] = w_q[train_index][i];
         if (train_x[i] == train_taken) begin
            if (w_q[train_index][i] != WMax) row_new[i] = w_q[train_index][i] + WIDTH'(1);
         end else begin
            if (w_q[train_index][i] != WMin) row_new[i] = w_q[train_index][i] - WIDTH'(1);
         end
      end
   end

   // Single row write port shared by the clear sweep and training.
   always_comb begin
      wr_en  = 1'b0;
      wr_row = train_index;
      for (int i = 0; i < NW; i++) wr_data[i] = row_new[i];
      if (state_q == StClear) begin
         wr_en  = 1'b1;
         wr_row = clr_ptr_q;
         for (int i = 0; i < NW; i++) wr_data[i] = '0;
      end else if (train_fire) begin
         wr_en = 1'b1;
      end
   end

   // Weight storage; cleared by the sweep, so it needs no reset of its own.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         for (int i = 0; i < NW; i++) w_q[wr_row][i] <= wr_data[i];
      end
   end

   // Lookup: hash the PC, forward a same-row training write, form the dot product.
   always_comb begin
      lk_idx   = lookup_pc[2 +: IDX] ^ lookup_pc[2+IDX +: IDX];
      lk_fire  = (state_q == StReady) && lookup_valid;
      lookup_x = {lookup_ghist, 1'b1};
      for (int i = 0; i < NW; i++) begin
         row_rd[i] = (train_fire && (train_index == lk_idx)) ? row_new[i] : w_q[lk_idx][i];
      end
      acc = '0;
      for (int i = 0; i < NW; i++) begin
         if (lookup_x[i]) acc = acc + SUM_W'(row_rd[i]);
         else             acc = acc - SUM_W'(row_rd[i]);
      end
   end

   // Next-state: clear sweep FSM, result register, saturating update counter.
   always_comb begin
      state_d        = state_q;
      clr_ptr_d      = clr_ptr_q;
      rd_valid_d     = lk_fire;
      rd_index_d     = rd_index_q;
      rd_sum_d       = rd_sum_q;
      rd_taken_d     = rd_taken_q;
      update_count_d = update_count_q;
      if (state_q == StClear) begin
         clr_ptr_d = clr_ptr_q + IDX'(1);
         if (clr_ptr_q == IDX'(NUM_ROWS - 1)) state_d = StReady;
      end
      if (lk_fire) begin
         rd_index_d = lk_idx;
         rd_sum_d   = acc;
         rd_taken_d = ~acc[SUM_W-1];
      end
      if (train_fire && (update_count_q != 16'hFFFF)) update_count_d = update_count_q + 16'd1;
   end

   // Control and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= StClear;
         clr_ptr_q      <= '0;
         rd_valid_q     <= 1'b0;
         rd_index_q     <= '0;
         rd_sum_q       <= '0;
         rd_taken_q     <= 1'b0;
         update_count_q <= '0;
      end else begin
         state_q        <= state_d;
         clr_ptr_q      <= clr_ptr_d;
         rd_valid_q     <= rd_valid_d;
         rd_index_q     <= rd_index_d;
         rd_sum_q       <= rd_sum_d;
         rd_taken_q     <= rd_taken_d;
         update_count_q <= update_count_d;
      end
   end

endmodule

// File: tb/tb_perceptron_weight_store.sv
// Scoreboard bench for perceptron_weight_store: a driver updates an integer reference model
// and queues expected lookup results; a monitor checks every cycle after the clock edge.
module tb_perceptron_weight_store;

   localparam int NR  = 64;
   localparam int HL  = 16;
   localparam int WD  = 8;
   localparam int PW  = 32;
   localparam int TH  = 44;
   localparam int IX  = 6;
   localparam int SW  = 14;
   localparam int NW  = 17;

   logic                 clk;
   logic                 rst_n;
   logic                 lookup_valid;
   logic [PW-1:0]        lookup_pc;
   logic [HL-1:0]        lookup_ghist;
   logic                 lookup_ready;
   logic                 rd_valid;
   logic [IX-1:0]        rd_index;
   logic signed [SW-1:0] rd_sum;
   logic                 rd_taken;
   logic                 train_valid;
   logic [IX-1:0]        train_index;
   logic [HL-1:0]        train_ghist;
   logic signed [SW-1:0] train_sum;
   logic                 train_taken;
   logic [15:0]          update_count;

   perceptron_weight_store #(
      .NUM_ROWS (NR),
      .HIST_LEN (HL),
      .WIDTH    (WD),
      .PC_WIDTH (PW),
      .THETA    (TH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .lookup_valid (lookup_valid),
      .lookup_pc    (lookup_pc),
      .lookup_ghist (lookup_ghist),
      .lookup_ready (lookup_ready),
      .rd_valid     (rd_valid),
      .rd_index     (rd_index),
      .rd_sum       (rd_sum),
      .rd_taken     (rd_taken),
      .train_valid  (train_valid),
      .train_index  (train_index),
      .train_ghist  (train_ghist),
      .train_sum    (train_sum),
      .train_taken  (train_taken),
      .update_count (update_count)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int sum;
      bit taken;
   } exp_t;

   exp_t sbq[$];
   int   wm [NR][NW];
   int   clr_cnt;
   bit   ready;
   int   exp_upd;
   bit   started;
   bit   rst_chk;
   int   tests;
   int   fails;

   function automatic int xval(input logic [HL-1:0] gh, input int i);
      if (i == 0) return 1;
      return gh[i-1] ? 1 : -1;
   endfunction

   function automatic void model_train(input int ti, input logic [HL-1:0] gh, input int s,
                                       input bit tt);
      int t;
      int nw;
      bit pred;
      int mag;
      pred = (s >= 0);
      mag  = (s < 0) ? -s : s;
      if ((pred != tt) || (mag <= TH)) begin
         t = tt ? 1 : -1;
         for (int i = 0; i < NW; i++) begin
            nw = wm[ti][i] + ((xval(gh, i) == t) ? 1 : -1);
            if (nw > 127)  nw = 127;
            if (nw < -128) nw = -128;
            wm[ti][i] = nw;
         end
         if (exp_upd < 65535) exp_upd++;
      end
   endfunction

   function automatic void model_lookup(input logic [PW-1:0] pc, input logic [HL-1:0] gh);
      int unsigned p;
      int idx;
      int s;
      exp_t e;
      p   = pc;
      idx = int'((p / 4) % 64) ^ int'((p / 256) % 64);
      s   = 0;
      for (int i = 0; i < NW; i++) s += wm[idx][i] * xval(gh, i);
      e.idx   = idx;
      e.sum   = s;
      e.taken = (s >= 0);
      sbq.push_back(e);
   endfunction

   // One cycle of stimulus; the model advances to the state after the next rising edge.
   task automatic drive(input bit rst, input bit lv, input logic [PW-1:0] pc,
                        input logic [HL-1:0] gh, input bit tv, input int ti,
                        input logic [HL-1:0] tgh, input int tsum, input bit tt);
      @(negedge clk);
      started      = 1'b1;
      rst_n        = rst;
      lookup_valid = lv;
      lookup_pc    = pc;
      lookup_ghist = gh;
      train_valid  = tv;
      train_index  = ti[IX-1:0];
      train_ghist  = tgh;
      train_sum    = tsum[SW-1:0];
      train_taken  = tt;
      rst_chk      = !rst;
      if (!rst) begin
         clr_cnt = 0;
         ready   = 1'b0;
         exp_upd = 0;
         sbq.delete();
      end else if (!ready) begin
         clr_cnt++;
         if (clr_cnt == NR) begin
            ready = 1'b1;
            for (int r = 0; r < NR; r++)
               for (int i = 0; i < NW; i++) wm[r][i] = 0;
         end
      end else begin
         if (tv) model_train(ti, tgh, tsum, tt);
         if (lv) model_lookup(pc, gh);
      end
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, '0, '0, 1'b0, 0, '0, 0, 1'b0);
   endtask

   task automatic rnd_cycle(input bit rst);
      logic [PW-1:0] pc;
      int            ti;
      pc = $urandom;
      ti = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1);
      if ($urandom_range(0, 3) == 0) pc = PW'(ti) << 2;
      drive(rst, 1'($urandom_range(0, 1)), pc, HL'($urandom), 1'($urandom_range(0, 1)), ti,
            HL'($urandom), int'($urandom_range(0, 200)) - 100, 1'($urandom_range(0, 1)));
   endtask

   // Monitor: compare DUT outputs with the model just after each rising edge.
   always begin
      exp_t e;
      bit   ev;
      @(posedge clk);
      #1;
      if (started) begin
         tests++;
         if (lookup_ready !== ready) begin
            fails++;
            $display("FAIL lookup_ready: got %0b want %0b at %0t", lookup_ready, ready, $time);
         end
         tests++;
         if (update_count !== 16'(exp_upd)) begin
            fails++;
            $display("FAIL update_count: got %0d want %0d at %0t", update_count, exp_upd, $time);
         end
         ev = (sbq.size() > 0);
         tests++;
         if (rd_valid !== ev) begin
            fails++;
            $display("FAIL rd_valid: got %0b want %0b at %0t", rd_valid, ev, $time);
         end
         if (ev) begin
            e = sbq.pop_front();
            tests++;
            if ((rd_index !== IX'(e.idx)) || (int'(rd_sum) != e.sum) || (rd_taken !== e.taken))
            begin
               fails++;
               $display("FAIL rd_result: got idx=%0d sum=%0d taken=%0b want idx=%0d sum=%0d taken=%0b at %0t",
                        rd_index, rd_sum, rd_taken, e.idx, e.sum, e.taken, $time);
            end
         end
         if (rst_chk) begin
            tests++;
            if ((rd_index !== '0) || (rd_sum !== '0) || (rd_taken !== 1'b0)) begin
               fails++;
               $display("FAIL reset_outputs: got idx=%0d sum=%0d taken=%0b want 0 0 0 at %0t",
                        rd_index, rd_sum, rd_taken, $time);
            end
         end
      end
   end

   initial begin
      tests = 0; fails = 0; started = 1'b0; rst_chk = 1'b0;
      clr_cnt = 0; ready = 1'b0; exp_upd = 0;
      rst_n = 1'b0; lookup_valid = 1'b0; lookup_pc = '0; lookup_ghist = '0;
      train_valid = 1'b0; train_index = '0; train_ghist = '0; train_sum = '0; train_taken = 1'b0;

      // Reset for two cycles, then the clear sweep with requests that must be ignored.
      rnd_cycle(1'b0);
      rnd_cycle(1'b0);
      for (int c = 0; c < NR; c++) rnd_cycle(1'b1);

      // Freshly cleared table and hash/latency.
      drive(1'b1, 1'b1, 32'h0000_0104, HL'($urandom), 1'b0, 0, '0, 0, 1'b0);
      idle();
      drive(1'b1, 1'b1, 32'hDEAD_BEEF, HL'($urandom), 1'b0, 0, '0, 0, 1'b0);

      // Row 5 to all +1, then read with all-taken and all-not-taken history.
      drive(1'b1, 1'b0, '0, '0, 1'b1, 5, 16'hFFFF, 0, 1'b1);
      drive(1'b1, 1'b1, 32'h0000_0014, 16'hFFFF, 1'b0, 0, '0, 0, 1'b0);
      drive(1'b1, 1'b1, 32'h0000_0014, 16'h0000, 1'b0, 0, '0, 0, 1'b0);

      // Threshold gating on row 7 at all +3.
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, '0, '0, 1'b1, 7, 16'hFFFF, 0, 1'b1);
      drive(1'b1, 1'b0, '0, '0, 1'b1, 7, 16'hFFFF, 51, 1'b1);
      drive(1'b1, 1'b1, 32'h0000_001C, 16'hFFFF, 1'b0, 0, '0, 0, 1'b0);
      drive(1'b1, 1'b0, '0, '0, 1'b1, 7, 16'hFFFF, 51, 1'b0);
      drive(1'b1, 1'b1, 32'h0000_001C, 16'hFFFF, 1'b0, 0, '0, 0, 1'b0);

      // Saturation on row 0 in both directions.
      for (int k = 0; k < 130; k++) drive(1'b1, 1'b0, '0, '0, 1'b1, 0, 16'hFFFF, 0, 1'b1);
      drive(1'b1, 1'b1, 32'h0000_0000, 16'hFFFF, 1'b0, 0, '0, 0, 1'b0);
      for (int k = 0; k < 260; k++) drive(1'b1, 1'b0, '0, '0, 1'b1, 0, 16'hFFFF, 0, 1'b0);
      drive(1'b1, 1'b1, 32'h0000_0000, 16'hFFFF, 1'b0, 0, '0, 0, 1'b0);

      // Same-cycle train and lookup of row 9.
      drive(1'b1, 1'b1, 32'h0000_0024, 16'hA5A5, 1'b1, 9, 16'h00FF, 0, 1'b1);
      drive(1'b1, 1'b1, 32'h0000_0024, 16'hA5A5, 1'b1, 9, 16'h00FF, -3, 1'b1);

      // Random traffic with a reset in the middle.
      for (int c = 0; c < 1500; c++) rnd_cycle(c != 700);

      for (int k = 0; k < 3; k++) idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
